prime_sieve_engine: RTL and testbench

Multi-cycle compute core behind the bus-mapped prime generator register block. The register block writes a limit and a start strobe; this engine finds every prime 2..limit by trial division against primes already found, and stores them in an internal table. The register block then reads the table by index through a registered read port, so it consumes this engine's results instead of computing them combinationally.

---
 rtl/prime_pkg.sv | 17 +
 rtl/prime_sieve_engine_if.sv | 27 ++
 rtl/prime_sieve_engine_seq_mod.sv | 63 ++++++
 rtl/prime_sieve_engine.sv | 145 ++++++++++++++
 tb/tb_prime_sieve_engine.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/prime_pkg.sv
// Shared types and default sizing for the prime sieve engine.
package prime_pkg;
   localparam int DEF_MAX_W   = 10;
   localparam int DEF_DEPTH   = 256;
   localparam int DEF_IDX_W   = 8;
   localparam int DEF_PRIME_W = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEXT,
      S_FETCH,
      S_CHECK,
      S_MOD,
      S_STORE,
      S_DONE
   } state_e;
endpackage

// File: rtl/prime_sieve_engine_if.sv
// Control, status and table read bundle between register block and engine.
interface prime_sieve_engine_if
   import prime_pkg::*;
#(
   parameter int MAX_W   = DEF_MAX_W,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int PRIME_W = DEF_PRIME_W
);
   logic               iStart;
   logic [MAX_W-1:0]   iMax;
   logic               oBusy;
   logic               oDone;
   logic [IDX_W:0]     oCount;
   logic               oOverflow;
   logic [IDX_W-1:0]   iRdIndex;
   logic [PRIME_W-1:0] oRdPrime;

   modport master (
      output iStart, iMax, iRdIndex,
      input  oBusy, oDone, oCount, oOverflow, oRdPrime
   );

   modport slave (
      input  iStart, iMax, iRdIndex,
      output oBusy, oDone, oCount, oOverflow, oRdPrime
   );
endinterface

// File: rtl/prime_sieve_engine_seq_mod.sv
// Restoring remainder unit; one quotient bit per cycle, first bit on the start edge.
module seq_mod
   import prime_pkg::*;
#(
   parameter int MAX_W = DEF_MAX_W
) (
   input  logic             iClk,
   input  logic             iReset,
   input  logic             iStart,
   input  logic [MAX_W-1:0] iDividend,
   input  logic [MAX_W-1:0] iDivisor,
   output logic             oDone,
   output logic [MAX_W-1:0] oRem
);
   localparam int CW = $clog2(MAX_W + 1);

   logic [MAX_W-1:0] rem_q, rem_d, dvd_q, dvd_d, div_q, div_d;
   logic [MAX_W-1:0] rem_in, dvd_in, div_in;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [MAX_W:0]   trial;

   always_comb begin
      rem_in = iStart ? '0 : rem_q;
      dvd_in = iStart ? iDividend : dvd_q;
      div_in = iStart ? iDivisor : div_q;
      trial  = {rem_in, dvd_in[MAX_W-1]};
      rem_d  = rem_q;
      dvd_d  = dvd_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (iStart || cnt_q != '0) begin
         if (trial >= {1'b0, div_in})
            rem_d = MAX_W'(trial - {1'b0, div_in});
         else
            rem_d = trial[MAX_W-1:0];
         dvd_d  = {dvd_in[MAX_W-2:0], 1'b0};
         div_d  = div_in;
         cnt_d  = iStart ? CW'(MAX_W - 1) : cnt_q - 1'b1;
         done_d = !iStart && (cnt_q == CW'(1));
      end
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         rem_q  <= '0;
         dvd_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dvd_q  <= dvd_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign oDone = done_q;
   assign oRem  = rem_q;
endmodule

// File: rtl/prime_sieve_engine.sv
// Trial-division prime finder filling an internal table, with a gated registered read port.
module prime_sieve_engine
   import prime_pkg::*;
#(
   parameter int MAX_W   = DEF_MAX_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int PRIME_W = DEF_PRIME_W
) (
   input  logic iClk,
   input  logic iReset,
   prime_sieve_engine_if.slave bus
);
   state_e             state_q, state_d;
   logic [MAX_W:0]     cand_q, cand_d;
   logic [MAX_W-1:0]   max_q, max_d;
   logic [IDX_W:0]     k_q, k_d, count_q, count_d;
   logic               ovf_q, ovf_d, done_q, done_d;
   logic [MAX_W-1:0]   p_q, p_d;
   logic [PRIME_W-1:0] rd_q, rd_d;
   logic [2*MAX_W-1:0] psq;
   logic               mod_start, mod_done, we;
   logic [MAX_W-1:0]   mod_rem;
   logic [MAX_W-1:0]   mem [DEPTH];

   seq_mod #(.MAX_W(MAX_W)) u_mod (
      .iClk      (iClk),
      .iReset    (iReset),
      .iStart    (mod_start),
      .iDividend (cand_q[MAX_W-1:0]),
      .iDivisor  (p_q),
      .oDone     (mod_done),
      .oRem      (mod_rem)
   );

   // full-width square so large divisors never alias below cand
   assign psq = {{MAX_W{1'b0}}, p_q} * {{MAX_W{1'b0}}, p_q};

   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      max_d     = max_q;
      k_d       = k_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      mod_start = 1'b0;
      we        = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.iStart) begin
               state_d = S_NEXT;
               max_d   = bus.iMax;
               cand_d  = (MAX_W+1)'(2);
               k_d     = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         S_NEXT: begin
            if (cand_q > {1'b0, max_q}) begin
               state_d = S_DONE;
            end else begin
               k_d     = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_CHECK;
         S_CHECK: begin
            if (k_q == count_q ||
                psq > {{(MAX_W-1){1'b0}}, cand_q}) begin
               state_d = S_STORE;
            end else begin
               mod_start = 1'b1;
               state_d   = S_MOD;
            end
         end
         S_MOD: begin
            if (mod_done) begin
               if (mod_rem == '0) begin
                  cand_d  = cand_q + 1'b1;
                  state_d = S_NEXT;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_STORE: begin
            we      = 1'b1;
            count_d = count_q + 1'b1;
            if (count_d == (IDX_W+1)'(DEPTH) &&
                cand_q < {1'b0, max_q}) begin
               ovf_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cand_d  = cand_q + 1'b1;
               state_d = S_NEXT;
            end
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE) && (state_q != S_DONE);
      p_d    = mem[k_q[IDX_W-1:0]];
      // old count gates the read, so a same-cycle STORE reads as empty
      if ({1'b0, bus.iRdIndex} < count_q)
         rd_d = {{(PRIME_W-MAX_W){1'b0}}, mem[bus.iRdIndex]};
      else
         rd_d = '0;
   end

   always_ff @(posedge iClk) begin
      if (we)
         mem[count_q[IDX_W-1:0]] <= cand_q[MAX_W-1:0];
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state_q <= S_IDLE;
         cand_q  <= '0;
         max_q   <= '0;
         k_q     <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         p_q     <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         max_q   <= max_d;
         k_q     <= k_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         p_q     <= p_d;
         rd_q    <= rd_d;
      end
   end

   assign bus.oBusy     = !(state_q == S_IDLE || state_q == S_DONE);
   assign bus.oDone     = done_q;
   assign bus.oCount    = count_q;
   assign bus.oOverflow = ovf_q;
   assign bus.oRdPrime  = rd_q;
endmodule

// File: tb/tb_prime_sieve_engine.sv
// Directed bench: full-size engine plus a 16-entry instance for overflow.
module tb_prime_sieve_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   prime_sieve_engine_if #(.MAX_W(10), .IDX_W(8), .PRIME_W(32)) bus ();
   prime_sieve_engine_if #(.MAX_W(10), .IDX_W(4), .PRIME_W(32)) bs ();

   prime_sieve_engine #(.MAX_W(10), .DEPTH(256), .IDX_W(8), .PRIME_W(32))
      u_dut (.iClk(clk), .iReset(rst), .bus(bus));

   prime_sieve_engine #(.MAX_W(10), .DEPTH(16), .IDX_W(4), .PRIME_W(32))
      u_small (.iClk(clk), .iReset(rst), .bus(bs));

   task automatic chk(input string tag, input int unsigned got,
                      input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic start(input int unsigned m);
      @(negedge clk);
      bus.iStart = 1'b1;
      bus.iMax   = 10'(m);
      @(negedge clk);
      bus.iStart = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 1'b0;
      int extra = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bus.oDone) seen = 1'b1;
      end
      chk({tag, "_done"}, seen, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.oDone) extra++;
      end
      chk({tag, "_once"}, extra, 0);
      chk({tag, "_idle"}, bus.oBusy, 0);
   endtask

   task automatic rd(input int idx, output int unsigned v);
      logic [7:0] ix;
      ix = 8'(idx);
      @(negedge clk);
      bus.iRdIndex = ix;
      @(negedge clk);
      v = bus.oRdPrime;
   endtask

   task automatic rd_s(input int idx, output int unsigned v);
      logic [3:0] ix;
      ix = 4'(idx);
      @(negedge clk);
      bs.iRdIndex = ix;
      @(negedge clk);
      v = bs.oRdPrime;
   endtask

   task automatic wait_done_s(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         @(negedge clk);
         if (bs.oDone) seen = 1'b1;
      end
      chk({tag, "_done"}, seen, 1);
   endtask

   int unsigned v;
   int          sawdone;
   int unsigned exp10 [4] = '{2, 3, 5, 7};

   initial begin
      bus.iStart   = 1'b0;
      bus.iMax     = '0;
      bus.iRdIndex = '0;
      bs.iStart    = 1'b0;
      bs.iMax      = '0;
      bs.iRdIndex  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.oBusy, 0);
      chk("rst_done", bus.oDone, 0);
      chk("rst_count", bus.oCount, 0);
      chk("rst_ovf", bus.oOverflow, 0);
      chk("rst_rd", bus.oRdPrime, 0);
      rst = 1'b0;

      start(10);
      chk("m10_busy", bus.oBusy, 1);
      wait_done("m10", 5000);
      chk("m10_count", bus.oCount, 4);
      for (int i = 0; i < 4; i++) begin
         rd(i, v);
         chk($sformatf("m10_idx%0d", i), v, exp10[i]);
      end
      rd(4, v);
      chk("m10_idx4", v, 0);

      @(negedge clk);
      bs.iStart = 1'b1;
      bs.iMax   = 10'd100;
      @(negedge clk);
      bs.iStart = 1'b0;
      wait_done_s("d16");
      chk("d16_count", bs.oCount, 16);
      chk("d16_ovf", bs.oOverflow, 1);
      rd_s(15, v);
      chk("d16_idx15", v, 53);
      @(negedge clk);
      bs.iStart = 1'b1;
      bs.iMax   = 10'd10;
      @(negedge clk);
      bs.iStart = 1'b0;
      wait_done_s("d16r");
      chk("d16r_ovf", bs.oOverflow, 0);
      chk("d16r_count", bs.oCount, 4);

      start(1);
      chk("m1_nodone", bus.oDone, 0);
      chk("m1_busy", bus.oBusy, 1);
      @(negedge clk);
      chk("m1_done", bus.oDone, 1);
      chk("m1_busyoff", bus.oBusy, 0);
      chk("m1_count", bus.oCount, 0);
      chk("m1_ovf", bus.oOverflow, 0);
      rd(0, v);
      chk("m1_idx0", v, 0);

      start(30);
      repeat (3) @(negedge clk);
      bus.iStart = 1'b1;
      bus.iMax   = 10'd5;
      @(negedge clk);
      bus.iStart = 1'b0;
      bus.iMax   = '0;
      chk("m30_stillbusy", bus.oBusy, 1);
      wait_done("m30", 10000);
      chk("m30_count", bus.oCount, 10);
      rd(9, v);
      chk("m30_idx9", v, 29);
      rd(10, v);
      chk("m30_idx10", v, 0);

      start(500);
      repeat (48) @(negedge clk);
      chk("m500_busy", bus.oBusy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", bus.oBusy, 0);
      chk("abort_count", bus.oCount, 0);
      sawdone = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.oDone) sawdone++;
      end
      chk("abort_nodone", sawdone, 0);
      start(20);
      wait_done("m20", 10000);
      chk("m20_count", bus.oCount, 8);
      rd(7, v);
      chk("m20_idx7", v, 19);

      start(1023);
      wait_done("m1023", 70000);
      chk("m1023_count", bus.oCount, 172);
      chk("m1023_ovf", bus.oOverflow, 0);
      rd(0, v);
      chk("m1023_idx0", v, 2);
      rd(171, v);
      chk("m1023_idx171", v, 1021);
      rd(172, v);
      chk("m1023_idx172", v, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
